// File: rtl/digit_scan_ctrl_if.sv
// Control and select bundle between the digit scan controller and its
// stimulus/consumer side. The master drives the scan controls, the slave
// (the controller) drives the registered decoder select outputs.
interface digit_scan_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic             mode_step;
   logic             step;
   logic [CNT_W-1:0] dwell;
   logic [3:0]       digit_mask;
   logic             sel1;
   logic             sel0;
   logic             sel_valid;
   logic             frame_done;

   modport master (
      output en, mode_step, step, dwell, digit_mask,
      input  sel1, sel0, sel_valid, frame_done
   );

   modport slave (
      input  en, mode_step, step, dwell, digit_mask,
      output sel1, sel0, sel_valid, frame_done
   );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Digit scan controller: produces the 2-bit select for a 2-to-4 one-hot
// decoder, dwelling on each enabled position for a programmable number of
// cycles (or until a step pulse), with one blanking cycle between positions
// and a frame_done pulse in the blank that wraps back to the first position.
module digit_scan_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   digit_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_valid_q, sel_valid_d;
   logic             frame_done_q, frame_done_d;

   logic [1:0]       low_idx;
   logic [1:0]       nxt_idx;
   logic [CNT_W-1:0] cnt_load;
   logic             mask_any;
   logic             dwell_end;

   // Lowest enabled position; only meaningful when the mask is non-zero.
   function automatic logic [1:0] lowest_set(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // First enabled position scanning cur+1, cur+2, cur+3, cur (mod 4).
   // Iterating from the farthest offset down lets the nearest one win.
   function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
      logic [1:0] r;
      logic [1:0] c;
      r = cur;
      for (int k = 4; k >= 1; k--) begin
         c = cur + 2'(k);
         if (m[c]) r = c;
      end
      return r;
   endfunction

   // Counter preload: a dwell of 0 behaves like a dwell of 1.
   function automatic logic [CNT_W-1:0] dwell_preload(input logic [CNT_W-1:0] d);
      return (d == '0) ? '0 : d - CNT_W'(1);
   endfunction

   assign mask_any  = (bus.digit_mask != 4'd0);
   assign low_idx   = lowest_set(bus.digit_mask);
   assign nxt_idx   = next_set(bus.digit_mask, idx_q);
   assign cnt_load  = dwell_preload(bus.dwell);
   assign dwell_end = bus.mode_step ? bus.step : (cnt_q == '0);

   // Next-state and registered-output computation for the scan sequencer.
   // frame_done is registered so it is visible during the blank itself; it is
   // therefore decided on the last DWELL cycle with the mask seen there.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      sel_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      if (!bus.en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (mask_any) begin
                  state_d     = DWELL;
                  idx_d       = low_idx;
                  cnt_d       = cnt_load;
                  sel_valid_d = 1'b1;
               end
            end
            DWELL: begin
               if (dwell_end) begin
                  state_d      = BLANK;
                  frame_done_d = mask_any && (nxt_idx <= idx_q);
               end else begin
                  sel_valid_d = 1'b1;
                  if (!bus.mode_step) cnt_d = cnt_q - CNT_W'(1);
               end
            end
            BLANK: begin
               if (!mask_any) begin
                  state_d = IDLE;
               end else begin
                  state_d     = DWELL;
                  idx_d       = nxt_idx;
                  cnt_d       = cnt_load;
                  sel_valid_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, position, counter and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         cnt_q        <= '0;
         sel_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         sel_valid_q  <= sel_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.sel1       = idx_q[1];
   assign bus.sel0       = idx_q[0];
   assign bus.sel_valid  = sel_valid_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: directed scenarios followed by
// randomized stimulus, checked cycle by cycle against a behavioural model.
module tb_digit_scan_ctrl;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [1:0] sel;
      logic       vld;
      logic       fd;
   } exp_t;

   logic clk;
   logic rst_n;

   digit_scan_ctrl_if #(.CNT_W(CNT_W)) bus ();

   digit_scan_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_cmp;
   int   n_mis;

   // Behavioural model: running/gap flags, shown position, cycles left
   bit       m_run;
   bit       m_gap;
   int       m_pos;
   int       m_left;
   bit       m_fd;

   function automatic int first_after(input logic [3:0] m, input int cur);
      for (int k = 1; k <= 4; k++) begin
         if (m[(cur + k) % 4]) return (cur + k) % 4;
      end
      return cur;
   endfunction

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return 0;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic ms, input logic st,
                             input logic [CNT_W-1:0] d, input logic [3:0] m);
      int span;
      bit finish;
      span = (d == 0) ? 1 : int'(d);
      m_fd = 1'b0;
      if (!r) begin
         m_run = 0; m_gap = 0; m_pos = 0; m_left = 1;
      end else if (!e) begin
         m_run = 0; m_gap = 0;
      end else if (!m_run) begin
         if (m != 0) begin
            m_run = 1; m_gap = 0; m_pos = lowest(m); m_left = span;
         end
      end else if (m_gap) begin
         if (m == 0) begin
            m_run = 0; m_gap = 0;
         end else begin
            m_gap = 0; m_pos = first_after(m, m_pos); m_left = span;
         end
      end else begin
         finish = ms ? st : (m_left == 1);
         if (finish) begin
            m_gap = 1;
            m_fd  = (m != 0) && (first_after(m, m_pos) <= m_pos);
         end else if (!ms) begin
            m_left = m_left - 1;
         end
      end
   endtask

   // Drive one cycle of inputs after the falling edge and record the expected
   // outputs following the next rising edge.
   task automatic cyc(input logic r, input logic e, input logic ms, input logic st,
                      input logic [CNT_W-1:0] d, input logic [3:0] m);
      exp_t ex;
      logic prev_rst;
      @(negedge clk);
      prev_rst       = rst_n;
      rst_n          = r;
      bus.en         = e;
      bus.mode_step  = ms;
      bus.step       = st;
      bus.dwell      = d;
      bus.digit_mask = m;
      model_step(r, e, ms, st, d, m);
      ex.sel = 2'(m_pos);
      ex.vld = m_run && !m_gap;
      ex.fd  = m_fd;
      sb_q.push_back(ex);
      if (prev_rst && !r) begin
         #1;
         n_cmp++;
         if ({bus.sel1, bus.sel0, bus.sel_valid, bus.frame_done} !== 4'b0000) begin
            n_mis++;
            $display("FAIL async_reset: got sel=%b%b vld=%b fd=%b, want all 0",
                     bus.sel1, bus.sel0, bus.sel_valid, bus.frame_done);
         end
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expected entry.
   always @(posedge clk) begin
      exp_t e;
      exp_t a;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         a.sel = {bus.sel1, bus.sel0};
         a.vld = bus.sel_valid;
         a.fd  = bus.frame_done;
         n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL outputs @%0t: got sel=%0d vld=%b fd=%b, want sel=%0d vld=%b fd=%b",
                     $time, a.sel, a.vld, a.fd, e.sel, e.vld, e.fd);
         end
      end
   end

   initial begin
      logic       r_en, r_ms, r_st, r_rst;
      logic [15:0] r_d;
      logic [3:0]  r_m;
      n_cmp = 0;
      n_mis = 0;
      m_run = 0; m_gap = 0; m_pos = 0; m_left = 1; m_fd = 0;
      rst_n          = 1'b0;
      bus.en         = 1'b0;
      bus.mode_step  = 1'b0;
      bus.step       = 1'b0;
      bus.dwell      = '0;
      bus.digit_mask = 4'd0;

      // Reset, then free-run over all four positions with dwell 3
      repeat (2) cyc(0, 0, 0, 0, 16'd3, 4'hF);
      repeat (9) cyc(1, 1, 0, 0, 16'd3, 4'hF);
      // Async reset while position 2 is displayed
      repeat (2) cyc(0, 1, 0, 0, 16'd3, 4'hF);
      repeat (36) cyc(1, 1, 0, 0, 16'd3, 4'hF);

      // Sparse mask
      repeat (20) cyc(1, 1, 0, 0, 16'd2, 4'b1010);

      // Dwell 0 with a single enabled position
      repeat (10) cyc(1, 1, 0, 0, 16'd0, 4'b0100);

      // Single-step: one pulse every 10 cycles, then a 6-cycle held step
      repeat (2) cyc(1, 0, 1, 0, 16'd3, 4'hF);
      repeat (3) cyc(1, 1, 1, 0, 16'd3, 4'hF);
      for (int p = 0; p < 5; p++) begin
         cyc(1, 1, 1, 1, 16'd3, 4'hF);
         repeat (9) cyc(1, 1, 1, 0, 16'd3, 4'hF);
      end
      repeat (6) cyc(1, 1, 1, 1, 16'd3, 4'hF);
      repeat (6) cyc(1, 1, 1, 0, 16'd3, 4'hF);
      // en=0 together with step: disable wins
      cyc(1, 0, 1, 1, 16'd3, 4'hF);

      // Disable during DWELL on position 1, then re-enable with a new mask
      repeat (6) cyc(1, 1, 0, 0, 16'd3, 4'hF);
      repeat (3) cyc(1, 0, 0, 0, 16'd3, 4'hF);
      repeat (10) cyc(1, 1, 0, 0, 16'd3, 4'b0110);
      // Mask cleared mid-DWELL, then restored
      repeat (8) cyc(1, 1, 0, 0, 16'd3, 4'h0);
      repeat (4) cyc(1, 1, 0, 0, 16'd3, 4'hF);

      // Dwell changed 3 -> 5 during a dwell
      repeat (2) cyc(1, 0, 0, 0, 16'd3, 4'hF);
      repeat (2) cyc(1, 1, 0, 0, 16'd3, 4'hF);
      repeat (20) cyc(1, 1, 0, 0, 16'd5, 4'hF);

      // Randomized operation
      r_ms = 0; r_d = 16'd2; r_m = 4'hF;
      for (int i = 0; i < 3000; i++) begin
         r_en  = ($urandom_range(0, 31) != 0);
         r_rst = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 63) == 0) r_ms = ~r_ms;
         if ($urandom_range(0, 19) == 0) r_d = 16'($urandom_range(0, 4));
         if ($urandom_range(0, 29) == 0) r_m = 4'($urandom_range(0, 15));
         r_st = ($urandom_range(0, 3) == 0);
         cyc(r_rst, r_en, r_ms, r_st, r_d, r_m);
      end

      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_mis++;
         $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
